// File: rtl/bullet_motion_unit.sv
// Single-bullet motion engine: launches from the tank centre on a fire rising
// edge, steps once per frame_tick, and pulses a collision on wall or edge strike.
module bullet_motion_unit #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned TANK_SIZE    = 32,
    parameter int unsigned BULLET_SIZE  = 4,
    parameter int unsigned BULLET_SPEED = 4
) (
    input  logic       fsm_clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire_active,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [1:0] tank_dir,
    input  logic       wall_hit,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_valid,
    output logic       bulletwallcollisionsignal
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned NEXT_W = 11;
    localparam int unsigned OFFSET = (TANK_SIZE - BULLET_SIZE) / 2;
    localparam int unsigned MAX_X  = SCREEN_W - BULLET_SIZE;
    localparam int unsigned MAX_Y  = SCREEN_H - BULLET_SIZE;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLYING = 2'd1,
        S_HIT    = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_fire_q;
    logic [1:0]                 r_dir;
    logic [POS_W-1:0]           r_bullet_x;
    logic [POS_W-1:0]           r_bullet_y;
    logic                       r_valid;
    logic                       r_collision;

    logic signed [NEXT_W-1:0]   w_dx;
    logic signed [NEXT_W-1:0]   w_dy;
    logic signed [NEXT_W-1:0]   w_next_x;
    logic signed [NEXT_W-1:0]   w_next_y;
    logic                       w_out_of_bounds;
    logic                       w_fire_rise;
    logic [POS_W-1:0]           w_launch_x;
    logic [POS_W-1:0]           w_launch_y;

    // Signed per-frame displacement for the latched heading
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (r_dir)
            DIR_UP:    w_dy = -$signed(NEXT_W'(BULLET_SPEED));
            DIR_RIGHT: w_dx =  $signed(NEXT_W'(BULLET_SPEED));
            DIR_DOWN:  w_dy =  $signed(NEXT_W'(BULLET_SPEED));
            DIR_LEFT:  w_dx = -$signed(NEXT_W'(BULLET_SPEED));
            default: begin
                w_dx = '0;
                w_dy = '0;
            end
        endcase
    end

    // One extra sign bit so a step past the top/left edge shows up as negative
    assign w_next_x = $signed({1'b0, r_bullet_x}) + w_dx;
    assign w_next_y = $signed({1'b0, r_bullet_y}) + w_dy;

    assign w_out_of_bounds = (w_next_x < $signed(NEXT_W'(0)))
                          || (w_next_y < $signed(NEXT_W'(0)))
                          || (w_next_x > $signed(NEXT_W'(MAX_X)))
                          || (w_next_y > $signed(NEXT_W'(MAX_Y)));

    assign w_fire_rise = fire_active && !r_fire_q;
    assign w_launch_x  = tank_x + POS_W'(OFFSET);
    assign w_launch_y  = tank_y + POS_W'(OFFSET);

    always_ff @(posedge fsm_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fire_q    <= 1'b0;
            r_dir       <= 2'd0;
            r_bullet_x  <= '0;
            r_bullet_y  <= '0;
            r_valid     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_fire_q    <= fire_active;
            r_collision <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_fire_rise) begin
                        r_state    <= S_FLYING;
                        r_dir      <= tank_dir;
                        r_bullet_x <= w_launch_x;
                        r_bullet_y <= w_launch_y;
                        r_valid    <= 1'b1;
                    end
                end
                S_FLYING: begin
                    // Fire dropping means upstream already resolved a tank hit
                    if (!fire_active) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end else if (frame_tick && (wall_hit || w_out_of_bounds)) begin
                        r_state     <= S_HIT;
                        r_valid     <= 1'b0;
                        r_collision <= 1'b1;
                    end else if (frame_tick) begin
                        r_bullet_x <= w_next_x[POS_W-1:0];
                        r_bullet_y <= w_next_y[POS_W-1:0];
                        r_valid    <= 1'b1;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                S_HIT: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bullet_x                  = r_bullet_x;
    assign bullet_y                  = r_bullet_y;
    assign bullet_valid              = r_valid;
    assign bulletwallcollisionsignal = r_collision;

endmodule
